// File: rtl/tb_irq_pkg.sv
// Shared types and constants for the interrupt stimulus generator.
// Imported by the LFSR and the generator top level.
package tb_irq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_RANDOM   = 2'd1,
        MODE_DIRECTED = 2'd2,
        MODE_BURST    = 2'd3
    } irq_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2
    } irq_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/tb_irq_lfsr.sv
// Right-shifting Galois LFSR; advances every cycle out of reset.
// SEED must be nonzero or the sequence locks up.
module tb_irq_lfsr
    import tb_irq_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [WIDTH-1:0] state_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_o <= SEED;
        end else begin
            state_o <= {1'b0, state_o[WIDTH-1:1]}
                     ^ (state_o[0] ? POLY : '0);
        end
    end

endmodule

// File: rtl/tb_irq_stim_gen.sv
// Interrupt stimulus generator: drives a level irq/id pair, checks acks,
// and reports ack count, bad-ack and timeout flags.
module tb_irq_stim_gen
    import tb_irq_pkg::*;
#(
    parameter int unsigned N_IRQ       = 32,
    parameter int unsigned ID_W        = 5,
    parameter int unsigned GAP_W       = 8,
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic [GAP_W-1:0] gap_min_i,
    input  logic [GAP_W-1:0] gap_max_i,
    input  logic [N_IRQ-1:0] id_mask_i,
    input  logic             dir_valid_i,
    input  logic [ID_W-1:0]  dir_id_i,
    output logic             irq_o,
    output logic [ID_W-1:0]  irq_id_o,
    input  logic             irq_ack_i,
    input  logic [ID_W-1:0]  irq_ack_id_i,
    output logic [15:0]      ack_cnt_o,
    output logic             err_o,
    output logic             timeout_o
);

    localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ID_W:0] NIRQ = (ID_W + 1)'(N_IRQ);

    logic [31:0] lfsr;
    logic [31:0] lfsr_unused;

    irq_state_e       state_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [TO_W-1:0]  req_cnt_q;
    logic [BC_W-1:0]  burst_cnt_q;
    logic             pend_vld_q;
    logic [ID_W-1:0]  pend_id_q;

    irq_mode_e        mode;
    logic             active;
    logic [GAP_W-1:0] rng, smr, off, rnd_gap;
    logic [ID_W-1:0]  c, hi_id, lo_id, rnd_id, cand_id;
    logic             hi_vld, rand_ok, cand_vld, burst_more;

    tb_irq_lfsr #(
        .WIDTH (32),
        .POLY  (LFSR_POLY),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .state_o (lfsr)
    );

    assign lfsr_unused = lfsr;
    assign mode   = irq_mode_e'(mode_i);
    assign active = enable_i && (mode != MODE_OFF);

    // Offset is masked to the next power of two, then folded once into range.
    always_comb begin
        rng = gap_max_i - gap_min_i;
        smr = rng;
        for (int i = 1; i < GAP_W; i++) begin
            smr = smr | (smr >> 1);
        end
        off = lfsr[GAP_W+7:8] & smr;
        if (off > rng) begin
            off = off - rng - GAP_W'(1);
        end
        rnd_gap = (gap_max_i < gap_min_i) ? gap_min_i : gap_min_i + off;
    end

    // First permitted ID at or above c, else lowest permitted ID (wrap).
    always_comb begin
        c = lfsr[ID_W-1:0];
        if ({1'b0, c} >= NIRQ) begin
            c = c - ID_W'(N_IRQ);
        end
        hi_id  = '0;
        lo_id  = '0;
        hi_vld = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (id_mask_i[i]) begin
                lo_id = ID_W'(i);
                if (ID_W'(i) >= c) begin
                    hi_id  = ID_W'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        rnd_id = hi_vld ? hi_id : lo_id;
    end

    always_comb begin
        rand_ok = ((mode == MODE_RANDOM) || (mode == MODE_BURST))
                && (|id_mask_i);
        cand_vld = pend_vld_q || rand_ok;
        cand_id  = pend_vld_q ? pend_id_q : rnd_id;
        burst_more = (mode == MODE_BURST)
                   && (burst_cnt_q < BC_W'(BURST_LEN - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            req_cnt_q   <= '0;
            burst_cnt_q <= '0;
            pend_vld_q  <= 1'b0;
            pend_id_q   <= '0;
            irq_o       <= 1'b0;
            irq_id_o    <= '0;
            ack_cnt_o   <= '0;
            err_o       <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    irq_o       <= 1'b0;
                    burst_cnt_q <= '0;
                    if (active) begin
                        gap_cnt_q <= rnd_gap;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!active) begin
                        state_q <= ST_IDLE;
                    end else if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end else if (cand_vld) begin
                        state_q    <= ST_REQ;
                        irq_o      <= 1'b1;
                        irq_id_o   <= cand_id;
                        req_cnt_q  <= TO_W'(1);
                        pend_vld_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (irq_ack_i) begin
                        irq_o <= 1'b0;
                        if (ack_cnt_o != 16'hFFFF) begin
                            ack_cnt_o <= ack_cnt_o + 16'd1;
                        end
                        if (irq_ack_id_i != irq_id_o) begin
                            err_o <= 1'b1;
                        end
                        if (!active) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                            if (burst_more) begin
                                gap_cnt_q   <= '0;
                                burst_cnt_q <= burst_cnt_q + BC_W'(1);
                            end else begin
                                gap_cnt_q   <= rnd_gap;
                                burst_cnt_q <= '0;
                            end
                        end
                    end else if ((ACK_TIMEOUT != 0)
                              && (req_cnt_q == TO_W'(ACK_TIMEOUT))) begin
                        timeout_o <= 1'b1;
                        irq_o     <= 1'b0;
                        gap_cnt_q <= rnd_gap;
                        state_q   <= ST_WAIT;
                    end else begin
                        req_cnt_q <= req_cnt_q + TO_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (irq_ack_i && (state_q != ST_REQ)) begin
                err_o <= 1'b1;
            end
            // A load in the consuming cycle wins and refills the slot.
            if (dir_valid_i) begin
                pend_vld_q <= 1'b1;
                pend_id_q  <= dir_id_i;
            end
        end
    end

endmodule

// File: tb/tb_tb_irq_stim_gen.sv
// Scoreboard bench for tb_irq_stim_gen: expected requests are queued by
// the stimulus and checked by a monitor as the DUT raises irq_o.
module tb_tb_irq_stim_gen;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [7:0]  gap_min_i = 8'd0;
    logic [7:0]  gap_max_i = 8'd0;
    logic [31:0] id_mask_i = 32'd0;
    logic        dir_valid_i = 1'b0;
    logic [4:0]  dir_id_i = 5'd0;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i = 1'b0;
    logic [4:0]  irq_ack_id_i = 5'd0;
    logic [15:0] ack_cnt_o;
    logic        err_o;
    logic        timeout_o;

    tb_irq_stim_gen #(
        .N_IRQ       (32),
        .ID_W        (5),
        .GAP_W       (8),
        .BURST_LEN   (4),
        .ACK_TIMEOUT (16),
        .SEED        (32'h1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .gap_min_i    (gap_min_i),
        .gap_max_i    (gap_max_i),
        .id_mask_i    (id_mask_i),
        .dir_valid_i  (dir_valid_i),
        .dir_id_i     (dir_id_i),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id_o),
        .irq_ack_i    (irq_ack_i),
        .irq_ack_id_i (irq_ack_id_i),
        .ack_cnt_o    (ack_cnt_o),
        .err_o        (err_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int lo_min;
        int lo_max;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   mon_reqs = 0;
    bit   ack_en = 1'b0;
    bit   ack_bad = 1'b0;
    bit   force_ack = 1'b0;
    logic [4:0] bad_id = 5'd0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic push(input int id, input int lo, input int hi);
        sb_q.push_back('{id: id, lo_min: lo, lo_max: hi});
    endtask

    // Core model: acks whatever is requested, one cycle after it appears.
    initial begin
        forever begin
            @(negedge clk);
            irq_ack_i    = force_ack || (ack_en && irq_o);
            irq_ack_id_i = ack_bad ? bad_id : irq_id_o;
        end
    end

    initial begin
        bit   prev;
        int   low;
        exp_t e;
        prev = 1'b0;
        low  = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev = 1'b0;
                low  = 0;
            end else begin
                if (irq_o && !prev) begin
                    mon_reqs++;
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL sb_unexpected: got id %0d expected none",
                                 irq_id_o);
                    end else begin
                        e = sb_q.pop_front();
                        chk("req_id", int'(irq_id_o), e.id);
                        if (e.lo_max >= 0)
                            chk_rng("low_gap", low, e.lo_min, e.lo_max);
                    end
                    low = 0;
                end else if (!irq_o) begin
                    low++;
                end
                prev = irq_o;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        enable_i = 1'b0;
        mode_i = 2'd0;
        dir_valid_i = 1'b0;
        ack_en = 1'b0;
        ack_bad = 1'b0;
        force_ack = 1'b0;
        #2 rst_ni = 1'b0;
        sb_q.delete();
        mon_reqs = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic wait_reqs(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (mon_reqs < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (mon_reqs < n) begin
            n_chk++;
            $display("FAIL %s_wait: got %0d requests expected %0d",
                     nm, mon_reqs, n);
        end
    endtask

    task automatic wait_irq(input string nm);
        int k;
        k = 0;
        while (!irq_o && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!irq_o) begin
            n_chk++;
            $display("FAIL %s_wait: got irq_o 0 expected 1", nm);
        end
    endtask

    task automatic stop_run(input string nm);
        @(negedge clk);
        enable_i = 1'b0;
        repeat (8) @(negedge clk);
        chk({nm, "_drain"}, sb_q.size(), 0);
    endtask

    task automatic dir_pulse(input logic [4:0] id);
        @(negedge clk);
        dir_valid_i = 1'b1;
        dir_id_i = id;
        @(negedge clk);
        dir_valid_i = 1'b0;
    endtask

    task automatic setup(input logic [1:0] m, input logic [31:0] mask,
                         input logic [7:0] gmin, input logic [7:0] gmax);
        @(negedge clk);
        mode_i = m;
        id_mask_i = mask;
        gap_min_i = gmin;
        gap_max_i = gmax;
    endtask

    initial begin
        int k;

        do_reset();
        @(posedge clk);
        #1;
        chk("rst_irq", int'(irq_o), 0);
        chk("rst_id", int'(irq_id_o), 0);
        chk("rst_ack_cnt", int'(ack_cnt_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_timeout", int'(timeout_o), 0);

        // Directed single request, acked one cycle later.
        setup(2'd2, 32'd0, 8'd0, 8'd0);
        ack_en = 1'b1;
        push(7, -1, -1);
        enable_i = 1'b1;
        dir_valid_i = 1'b1;
        dir_id_i = 5'd7;
        @(negedge clk);
        dir_valid_i = 1'b0;
        wait_irq("dir");
        @(posedge clk);
        #1;
        chk("dir_ack_drop", int'(irq_o), 0);
        chk("dir_ack_cnt", int'(ack_cnt_o), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("dir_no_pending", int'(irq_o), 0);
        stop_run("dir");

        // Random with a single permitted ID.
        do_reset();
        setup(2'd1, 32'h0000_0010, 8'd0, 8'd2);
        ack_en = 1'b1;
        push(4, -1, -1);
        for (int i = 1; i < 50; i++) push(4, 1, 3);
        enable_i = 1'b1;
        wait_reqs("rand", 50, 1000);
        stop_run("rand");
        chk("rand_ack_cnt", int'(ack_cnt_o), 50);
        chk("rand_err", int'(err_o), 0);

        // Gap bounds 3..10 give 4..11 low cycles.
        do_reset();
        setup(2'd1, 32'h8000_0000, 8'd3, 8'd10);
        ack_en = 1'b1;
        push(31, -1, -1);
        for (int i = 1; i < 20; i++) push(31, 4, 11);
        enable_i = 1'b1;
        wait_reqs("bounds", 20, 1000);
        stop_run("bounds");
        chk("bounds_ack_cnt", int'(ack_cnt_o), 20);

        // Inverted bounds use gap_min.
        do_reset();
        setup(2'd1, 32'h0000_0001, 8'd5, 8'd2);
        ack_en = 1'b1;
        push(0, -1, -1);
        for (int i = 1; i < 10; i++) push(0, 6, 6);
        enable_i = 1'b1;
        wait_reqs("inv", 10, 500);
        stop_run("inv");

        // Burst of four, then a 20-cycle gap.
        do_reset();
        setup(2'd3, 32'h0000_0200, 8'd20, 8'd20);
        ack_en = 1'b1;
        push(9, -1, -1);
        push(9, 1, 1); push(9, 1, 1); push(9, 1, 1);
        push(9, 21, 21);
        push(9, 1, 1); push(9, 1, 1); push(9, 1, 1);
        enable_i = 1'b1;
        wait_reqs("burst", 8, 500);
        stop_run("burst");
        chk("burst_ack_cnt", int'(ack_cnt_o), 8);

        // Mismatched ack ID still counts but flags an error.
        do_reset();
        setup(2'd2, 32'd0, 8'd0, 8'd0);
        ack_en = 1'b1;
        ack_bad = 1'b1;
        bad_id = 5'd3;
        push(5, -1, -1);
        enable_i = 1'b1;
        dir_pulse(5'd5);
        wait_reqs("bad", 1, 50);
        ack_en = 1'b0;
        ack_bad = 1'b0;
        chk("bad_err", int'(err_o), 1);
        chk("bad_ack_cnt", int'(ack_cnt_o), 1);
        chk("bad_irq_drop", int'(irq_o), 0);

        // Asynchronous reset in the middle of a request.
        push(21, -1, -1);
        dir_pulse(5'd21);
        wait_reqs("arst", 2, 50);
        repeat (3) @(posedge clk);
        chk("arst_pre_irq", int'(irq_o), 1);
        #3 rst_ni = 1'b0;
        #1;
        chk("arst_irq", int'(irq_o), 0);
        chk("arst_id", int'(irq_id_o), 0);
        chk("arst_ack_cnt", int'(ack_cnt_o), 0);
        chk("arst_err", int'(err_o), 0);
        chk("arst_timeout", int'(timeout_o), 0);

        // Unacked request times out after 16 cycles; later ack is stray.
        do_reset();
        setup(2'd2, 32'd0, 8'd0, 8'd0);
        push(12, -1, -1);
        enable_i = 1'b1;
        dir_pulse(5'd12);
        wait_irq("to");
        k = 0;
        while (irq_o && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("to_len", k, 16);
        chk("to_flag", int'(timeout_o), 1);
        chk("to_irq", int'(irq_o), 0);
        chk("to_err", int'(err_o), 0);
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("stray_err", int'(err_o), 1);
        chk("stray_ack_cnt", int'(ack_cnt_o), 0);
        stop_run("to");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
